bht_upd_ctrl: RTL and testbench

- Sequences all writes into the 1024x10 local branch history table.
- Buffers committed-branch direction updates from retire in a small FIFO and drains them one per cycle to the BHT single write port.
- Runs a scrub engine that zeroes every history entry on request (context switch, predictor reset) by shifting in not-taken bits.
- Flags fetch-side reads whose index still has an update pending, so history there is known stale.

---
 rtl/bht_upd_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_bht_upd_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_upd_ctrl.sv
// rtl/bht_upd_ctrl.sv - write sequencer for the local branch history table
//
// Purpose:
//   Owns the single write port of the 2**IDX_W x HIST_W branch history table.
//   Retire-side direction updates are queued in a small FIFO and drained one per
//   cycle. A scrub engine clears the whole table on request by shifting
//   not-taken bits into every entry. Fetch-side reads whose index is still
//   queued are flagged as stale.
//
// Optional feature macro: BHT_UPD_BYPASS_EN
//   When defined, an update that arrives while the queue is empty and the write
//   port is free goes straight to the table in the same cycle.
//
// Ports:
//   clock, reset_n            core clock, asynchronous active-low reset
//   cm_valid_i/index_i/brdir_i committed branch update (valid/ready handshake)
//   cm_ready_o                update accepted when cm_valid_i & cm_ready_o
//   scrub_req_i               pulse: start a full-table scrub
//   scrub_busy_o              scrub in progress
//   scrub_done_o              one-cycle pulse when the scrub completes
//   wr_hold_i                 table write port blocked this cycle
//   rd_index_i, pend_hit_o    fetch read index / it matches a queued update
//   bht_wt_index_o            table write index
//   bht_brdir_o               table shift-in bit
//   bht_brdir_se_o            table shift-in enable

module bht_upd_ctrl #(
  parameter int IDX_W      = 10,
  parameter int HIST_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cm_valid_i,
  input  logic [IDX_W-1:0] cm_index_i,
  input  logic             cm_brdir_i,
  output logic             cm_ready_o,
  input  logic             scrub_req_i,
  output logic             scrub_busy_o,
  output logic             scrub_done_o,
  input  logic             wr_hold_i,
  input  logic [IDX_W-1:0] rd_index_i,
  output logic             pend_hit_o,
  output logic [IDX_W-1:0] bht_wt_index_o,
  output logic             bht_brdir_o,
  output logic             bht_brdir_se_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int SH_W  = (HIST_W > 1) ? $clog2(HIST_W) : 1;

  localparam logic [PTR_W:0]  DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [SH_W-1:0] SH_LAST  = SH_W'(HIST_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_SCRUB = 1'b1;

  logic [0:0]            r_state;
  logic [IDX_W-1:0]      r_mem_idx [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_dir;
  logic [FIFO_DEPTH-1:0] r_vld;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;
  logic [IDX_W-1:0]      r_scr_idx;
  logic [SH_W-1:0]       r_scr_sh;
  logic                  r_done;
  logic [IDX_W-1:0]      r_last_idx;
  logic                  r_last_dir;

  logic             w_run;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_bypass;
  logic             w_scr_wr;
  logic             w_pend;
  logic [IDX_W-1:0] w_idx;
  logic             w_dir;

  always_comb begin
    w_run   = (r_state == ST_RUN);
    w_full  = (r_count == DEPTH_C);
    w_empty = (r_count == '0);

    // A scrub request wins over everything in its cycle: nothing is accepted
    // and the queue head is not issued, so every queued update is dropped.
    cm_ready_o = w_run && !w_full && !scrub_req_i;
    w_pop      = w_run && !w_empty && !wr_hold_i && !scrub_req_i;
`ifdef BHT_UPD_BYPASS_EN
    w_bypass   = w_run && w_empty && !wr_hold_i && cm_valid_i && !scrub_req_i;
`else
    w_bypass   = 1'b0;
`endif
    w_push     = cm_valid_i && cm_ready_o && !w_bypass;
    w_scr_wr   = !w_run && !wr_hold_i;

    if (w_scr_wr) begin
      w_idx = r_scr_idx;
      w_dir = 1'b0;
    end else if (w_pop) begin
      w_idx = r_mem_idx[r_rd_ptr];
      w_dir = r_mem_dir[r_rd_ptr];
    end else begin
      w_idx = cm_index_i;
      w_dir = cm_brdir_i;
    end

    // Bypassed updates are never pushed, so they never count as pending.
    w_pend = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (r_vld[i] && (r_mem_idx[i] == rd_index_i)) begin
        w_pend = 1'b1;
      end
    end

    bht_brdir_se_o = w_scr_wr || w_pop || w_bypass;
    // Write index/bit hold their last issued value while the enable is low.
    bht_wt_index_o = bht_brdir_se_o ? w_idx : r_last_idx;
    bht_brdir_o    = bht_brdir_se_o ? w_dir : r_last_dir;
    pend_hit_o     = w_run && w_pend;
    scrub_busy_o   = !w_run;
    scrub_done_o   = r_done;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_RUN;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_idx[i] <= '0;
      end
      r_mem_dir  <= '0;
      r_vld      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_scr_idx  <= '0;
      r_scr_sh   <= '0;
      r_done     <= 1'b0;
      r_last_idx <= '0;
      r_last_dir <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bht_brdir_se_o) begin
        r_last_idx <= w_idx;
        r_last_dir <= w_dir;
      end
      if (w_run) begin
        if (scrub_req_i) begin
          r_state  <= ST_SCRUB;
          r_vld    <= '0;
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          // Push and pop never target the same slot: no pop when empty,
          // no push when full.
          if (w_push) begin
            r_mem_idx[r_wr_ptr] <= cm_index_i;
            r_mem_dir[r_wr_ptr] <= cm_brdir_i;
            r_vld[r_wr_ptr]     <= 1'b1;
            r_wr_ptr            <= r_wr_ptr + 1'b1;
          end
          if (w_pop) begin
            r_vld[r_rd_ptr] <= 1'b0;
            r_rd_ptr        <= r_rd_ptr + 1'b1;
          end
          if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
          end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
          end
        end
      end else if (!wr_hold_i) begin
        if (r_scr_sh == SH_LAST) begin
          r_scr_sh <= '0;
          if (r_scr_idx == IDX_LAST) begin
            r_scr_idx <= '0;
            r_state   <= ST_RUN;
            r_done    <= 1'b1;
          end else begin
            r_scr_idx <= r_scr_idx + 1'b1;
          end
        end else begin
          r_scr_sh <= r_scr_sh + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bht_upd_ctrl.sv
// tb/tb_bht_upd_ctrl.sv - self-checking bench for bht_upd_ctrl

module tb_bht_upd_ctrl;

  localparam int IDX_W      = 10;
  localparam int HIST_W     = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int TOTAL      = (1 << IDX_W) * HIST_W;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             cm_valid_i;
  logic [IDX_W-1:0] cm_index_i;
  logic             cm_brdir_i;
  logic             cm_ready_o;
  logic             scrub_req_i;
  logic             scrub_busy_o;
  logic             scrub_done_o;
  logic             wr_hold_i;
  logic [IDX_W-1:0] rd_index_i;
  logic             pend_hit_o;
  logic [IDX_W-1:0] bht_wt_index_o;
  logic             bht_brdir_o;
  logic             bht_brdir_se_o;

  bht_upd_ctrl #(.IDX_W(IDX_W), .HIST_W(HIST_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .cm_valid_i     (cm_valid_i),
    .cm_index_i     (cm_index_i),
    .cm_brdir_i     (cm_brdir_i),
    .cm_ready_o     (cm_ready_o),
    .scrub_req_i    (scrub_req_i),
    .scrub_busy_o   (scrub_busy_o),
    .scrub_done_o   (scrub_done_o),
    .wr_hold_i      (wr_hold_i),
    .rd_index_i     (rd_index_i),
    .pend_hit_o     (pend_hit_o),
    .bht_wt_index_o (bht_wt_index_o),
    .bht_brdir_o    (bht_brdir_o),
    .bht_brdir_se_o (bht_brdir_se_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             dir;
  } upd_t;

  upd_t             q[$];
  bit               m_scrub;
  int               m_nwr;
  bit               m_done;
  logic [IDX_W-1:0] m_last_idx;
  logic             m_last_dir;
  int               scrub_se_seen;
  int               done_seen;
  int               n_checks;
  int               n_errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_scrub    = 0;
    m_nwr      = 0;
    m_done     = 0;
    m_last_idx = '0;
    m_last_dir = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_se"},   bht_brdir_se_o, 0);
    chk({tag, "_idx"},  bht_wt_index_o, 0);
    chk({tag, "_dir"},  bht_brdir_o, 0);
    chk({tag, "_busy"}, scrub_busy_o, 0);
    chk({tag, "_done"}, scrub_done_o, 0);
    chk({tag, "_pend"}, pend_hit_o, 0);
  endtask

  // One clock cycle: drive inputs, compare every output with the model, then
  // advance the model by what the write port and handshake did this cycle.
  task automatic cyc(input logic v, input logic [IDX_W-1:0] idx, input logic d,
                     input logic sreq, input logic hold, input logic [IDX_W-1:0] rd);
    logic             e_ready, e_se, e_dir, e_pend, e_busy, e_bypass;
    logic [IDX_W-1:0] e_idx;
    @(negedge clock);
    cm_valid_i  = v;
    cm_index_i  = idx;
    cm_brdir_i  = d;
    scrub_req_i = sreq;
    wr_hold_i   = hold;
    rd_index_i  = rd;
    #1;
    e_idx    = m_last_idx;
    e_dir    = m_last_dir;
    e_bypass = 1'b0;
    if (!m_scrub) begin
      e_busy  = 1'b0;
      e_ready = (q.size() < FIFO_DEPTH) && !sreq;
      e_se    = (q.size() > 0) && !hold && !sreq;
      e_pend  = 1'b0;
      foreach (q[i]) if (q[i].idx == rd) e_pend = 1'b1;
      if (e_se) begin
        e_idx = q[0].idx;
        e_dir = q[0].dir;
      end
`ifdef BHT_UPD_BYPASS_EN
      if (q.size() == 0 && !hold && v && !sreq) begin
        e_bypass = 1'b1;
        e_se     = 1'b1;
        e_idx    = idx;
        e_dir    = d;
      end
`endif
    end else begin
      e_busy  = 1'b1;
      e_ready = 1'b0;
      e_pend  = 1'b0;
      e_se    = !hold;
      if (e_se) begin
        e_idx = IDX_W'(m_nwr / HIST_W);
        e_dir = 1'b0;
      end
    end
    chk("ready", cm_ready_o, e_ready);
    chk("se",    bht_brdir_se_o, e_se);
    chk("index", bht_wt_index_o, e_idx);
    chk("dir",   bht_brdir_o, e_dir);
    chk("pend",  pend_hit_o, e_pend);
    chk("busy",  scrub_busy_o, e_busy);
    chk("done",  scrub_done_o, m_done);
    if (bht_brdir_se_o && scrub_busy_o) scrub_se_seen++;
    if (scrub_done_o) done_seen++;

    m_done = 0;
    if (e_se) begin
      m_last_idx = e_idx;
      m_last_dir = e_dir;
    end
    if (!m_scrub) begin
      if (sreq) begin
        q.delete();
        m_scrub = 1;
        m_nwr   = 0;
      end else begin
        if (e_se && !e_bypass) void'(q.pop_front());
        if (v && e_ready && !e_bypass) q.push_back('{idx: idx, dir: d});
      end
    end else if (!hold) begin
      m_nwr++;
      if (m_nwr == TOTAL) begin
        m_scrub = 0;
        m_done  = 1;
      end
    end
  endtask

  task automatic idle(input int n, input logic [IDX_W-1:0] rd);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, 0, rd);
  endtask

  task automatic rand_cyc(input bit allow_hold);
    logic             v, d, h;
    logic [IDX_W-1:0] idx, rd;
    v   = ($urandom_range(0, 99) < 60);
    d   = 1'($urandom_range(0, 1));
    h   = allow_hold && ($urandom_range(0, 99) < 25);
    idx = IDX_W'($urandom_range(0, 15)) | ($urandom_range(0, 1) ? 10'h200 : 10'h000);
    rd  = IDX_W'($urandom_range(0, 15)) | ($urandom_range(0, 3) == 0 ? 10'h200 : 10'h000);
    cyc(v, idx, d, 0, h, rd);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    scrub_se_seen = 0;
    done_seen     = 0;
    reset_n       = 1'b0;
    cm_valid_i    = 1'b0;
    cm_index_i    = '0;
    cm_brdir_i    = 1'b0;
    scrub_req_i   = 1'b0;
    wr_hold_i     = 1'b0;
    rd_index_i    = '0;
    model_reset();

    repeat (3) @(negedge clock);
    #1;
    chk_reset_vals("rst");
    @(negedge clock);
    reset_n = 1'b1;

    idle(4, '0);

    // Single update, then back-pressure with the port held.
    cyc(1, 10'h155, 1, 0, 0, 10'h155);
    idle(3, 10'h155);
    for (int i = 0; i < 5; i++) cyc(1, IDX_W'(10'h20 + i), 1'(i), 0, 1, 10'h22);
    cyc(1, 10'h24, 0, 0, 0, 10'h24);
    cyc(1, 10'h24, 0, 0, 0, 10'h24);
    idle(6, 10'h24);

    // Same-index ordering.
    cyc(1, 10'h3, 1, 0, 0, 10'h3);
    cyc(1, 10'h3, 0, 0, 0, 10'h3);
    cyc(1, 10'h3, 1, 0, 0, 10'h3);
    idle(5, 10'h3);

    for (int i = 0; i < 3000; i++) rand_cyc(1);
    idle(6, '0);

    // Scrub with two queued updates; hold three cycles mid-scrub and
    // re-request once to confirm no restart.
    cyc(1, 10'h11, 1, 0, 1, 10'h11);
    cyc(1, 10'h12, 0, 0, 1, 10'h12);
    cyc(0, '0, 0, 1, 0, 10'h11);
    scrub_se_seen = 0;
    done_seen     = 0;
    for (int i = 0; i < TOTAL + 100 && done_seen == 0; i++) begin
      cyc(1'($urandom_range(0, 1)), 10'h11, 1, (i == 1000), (i >= 500 && i < 503), 10'h11);
    end
    chk("scrub_writes", scrub_se_seen, TOTAL);
    chk("done_pulses", done_seen, 1);
    idle(3, '0);
    for (int i = 0; i < 200; i++) rand_cyc(1);

    // Reset in the middle of a scrub.
    cyc(0, '0, 0, 1, 0, '0);
    for (int i = 0; i < 50; i++) rand_cyc(1);
    @(negedge clock);
    cm_valid_i = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    idle(3, '0);
    for (int i = 0; i < 300; i++) rand_cyc(1);
    idle(6, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
